sata_pqualify: RTL
==================

SATA_PQUALIFY -- requirements
Module: sata_pqualify

Interface
REQ-001 SHALL have parameter ASSERT_COUNTS, default 4: consecutive high samples of i_sig required before o_sig asserts; legal range 1..255.
REQ-002 SHALL have parameter DEASSERT_COUNTS, default 4: consecutive low samples of i_sig required before o_sig deasserts; legal range 1..255.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port i_sig  input  1  raw, possibly glitchy, synchronous level.
REQ-006 SHALL have port o_sig  output  1  qualified (debounced) level, registered.
REQ-007 SHALL have port o_rise  output  1  one-cycle strobe, high on the first cycle o_sig is 1.
REQ-008 SHALL have port o_fall  output  1  one-cycle strobe, high on the first cycle o_sig is 0 after being 1.
REQ-009 SHALL have port o_glitch  output  1  one-cycle strobe, high when a qualification attempt aborts.

Function
REQ-010 SHALL implement a four-state FSM: IDLE (o_sig=0), QUAL_ON (o_sig=0), ON (o_sig=1), QUAL_OFF (o_sig=1).
REQ-011 SHALL use one down-counter of width $clog2(max(ASSERT_COUNTS,DEASSERT_COUNTS)+1), never wrapping below 0 or exceeding the loaded value.
REQ-012 IDLE, i_sig=1: if ASSERT_COUNTS==1 go to ON directly; else go to QUAL_ON with counter=ASSERT_COUNTS-1.
REQ-013 QUAL_ON, i_sig=1, counter>1: decrement, remain.
REQ-014 QUAL_ON, i_sig=1, counter==1: go to ON; counter=0.
REQ-015 QUAL_ON, i_sig=0: go to IDLE, counter=0, o_glitch=1 next cycle.
REQ-016 ON, i_sig=0: if DEASSERT_COUNTS==1 go to IDLE; else go to QUAL_OFF with counter=DEASSERT_COUNTS-1.
REQ-017 QUAL_OFF, i_sig=0, counter>1: decrement, remain; counter==1: go to IDLE.
REQ-018 QUAL_OFF, i_sig=1: return to ON, counter=0, o_glitch=1 next cycle.
REQ-019 IDLE with i_sig=0 and ON with i_sig=1 SHALL hold state; no strobes.
REQ-020 Net latency: o_sig SHALL rise on the edge that samples the ASSERT_COUNTS-th consecutive high, i.e. visible one cycle after that sample; symmetric for fall with DEASSERT_COUNTS.
REQ-021 o_rise SHALL equal o_sig & !(previous o_sig); o_fall SHALL equal !o_sig & previous o_sig; both registered, coincident with the o_sig transition cycle.
REQ-022 o_rise, o_fall, o_glitch SHALL be mutually exclusive and never high two consecutive cycles.
REQ-023 A continuously toggling i_sig (period 2) with both counts >1 SHALL never change o_sig and SHALL pulse o_glitch every other cycle.
REQ-024 All outputs SHALL be registered; no combinational path from i_sig to any output.

Reset
REQ-025 When i_reset_n=0 at a clock edge, next cycle SHALL have state=IDLE, counter=0, o_sig=0, o_rise=0, o_fall=0, o_glitch=0, regardless of i_sig or current state.
REQ-026 Reset during ON or QUAL_OFF SHALL drop o_sig without asserting o_fall.
REQ-027 First edge after reset release SHALL treat i_sig as a fresh sample (qualification starts from zero).
REQ-028 Initial values SHALL match reset values for simulation/formal.

Verification (ASSERT_COUNTS=4, DEASSERT_COUNTS=2 unless noted)
REQ-029 i_reset_n=0 five cycles with i_sig=1 -> o_sig/strobes 0 throughout; release, i_sig held 1 -> o_sig=1 and o_rise=1 after 4th sampled high, o_rise 0 the next cycle.
REQ-030 From IDLE, i_sig=1 for 3 cycles then 0 -> o_sig stays 0; o_glitch=1 exactly one cycle after the low sample.
REQ-031 From ON, i_sig=0 one cycle then 1 -> o_sig stays 1, o_fall never asserts, o_glitch one cycle.
REQ-032 From ON, i_sig=0 two cycles -> o_sig=0 with o_fall=1 one cycle after second low sample.
REQ-033 i_reset_n=0 while in QUAL_OFF -> o_sig=0 next cycle, o_fall=0, o_glitch=0.
REQ-034 ASSERT_COUNTS=DEASSERT_COUNTS=1 -> o_sig equals i_sig delayed one cycle; o_glitch never asserts.
REQ-035 Formal: assert o_sig==(state==ON||state==QUAL_OFF), counter bound per REQ-011, strobe exclusivity per REQ-022; cover o_rise, o_fall, o_glitch.

Source files
------------

// File: rtl/sata_pqualify.sv
// Debounces a raw synchronous level: o_sig follows i_sig only after a run of
// consecutive agreeing samples, with registered rise/fall/glitch strobes.
module sata_pqualify #(
  parameter int unsigned ASSERT_COUNTS   = 4,
  parameter int unsigned DEASSERT_COUNTS = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_sig,
  output logic o_sig,
  output logic o_rise,
  output logic o_fall,
  output logic o_glitch
);

  localparam int unsigned MAX_COUNTS = (ASSERT_COUNTS > DEASSERT_COUNTS) ?
                                       ASSERT_COUNTS : DEASSERT_COUNTS;
  localparam int unsigned CW = $clog2(MAX_COUNTS + 1);
  localparam logic [CW-1:0] ASSERT_LOAD   = CW'(ASSERT_COUNTS - 1);
  localparam logic [CW-1:0] DEASSERT_LOAD = CW'(DEASSERT_COUNTS - 1);
  localparam logic [CW-1:0] CNT_ZERO      = CW'(0);
  localparam logic [CW-1:0] CNT_ONE       = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL_ON  = 2'd1,
    ON       = 2'd2,
    QUAL_OFF = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] next_cnt;
  logic          next_glitch;
  logic          next_sig;

  // State, counter and registered outputs; o_sig is always derived from the
  // state being entered, so it tracks ON/QUAL_OFF exactly.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      cnt      <= CNT_ZERO;
      o_sig    <= 1'b0;
      o_rise   <= 1'b0;
      o_fall   <= 1'b0;
      o_glitch <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      o_sig    <= next_sig;
      o_rise   <= next_sig & ~o_sig;
      o_fall   <= ~next_sig & o_sig;
      o_glitch <= next_glitch;
    end
  end

  // Next-state and counter: count remaining samples needed to qualify.
  always_comb begin
    next_state  = state;
    next_cnt    = cnt;
    next_glitch = 1'b0;
    case (state)
      IDLE: begin
        if (i_sig) begin
          if (ASSERT_COUNTS == 1) begin
            next_state = ON;
          end else begin
            next_state = QUAL_ON;
            next_cnt   = ASSERT_LOAD;
          end
        end
      end
      QUAL_ON: begin
        if (!i_sig) begin
          next_state  = IDLE;
          next_cnt    = CNT_ZERO;
          next_glitch = 1'b1;
        end else if (cnt > CNT_ONE) begin
          next_cnt = cnt - CNT_ONE;
        end else begin
          next_state = ON;
          next_cnt   = CNT_ZERO;
        end
      end
      ON: begin
        if (!i_sig) begin
          if (DEASSERT_COUNTS == 1) begin
            next_state = IDLE;
          end else begin
            next_state = QUAL_OFF;
            next_cnt   = DEASSERT_LOAD;
          end
        end
      end
      QUAL_OFF: begin
        if (i_sig) begin
          next_state  = ON;
          next_cnt    = CNT_ZERO;
          next_glitch = 1'b1;
        end else if (cnt > CNT_ONE) begin
          next_cnt = cnt - CNT_ONE;
        end else begin
          next_state = IDLE;
          next_cnt   = CNT_ZERO;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = CNT_ZERO;
      end
    endcase
  end

  // Output decode of the qualified level from the state being entered.
  always_comb begin
    next_sig = 1'b0;
    if ((next_state == ON) || (next_state == QUAL_OFF)) begin
      next_sig = 1'b1;
    end
  end

endmodule
